delta_1st_compute: RTL and testbench



---
 rtl/delta_1st_compute.sv | 232 +++++++++++++++++++++++
 tb/tb_delta_1st_compute.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delta_1st_compute.sv
// First-order regression delta over the cepstrum memory:
// d[t][k] = ((c[t+1]-c[t-1]) + 2*(c[t+2]-c[t-2])) / 10, frame indices clamped to the utterance.
module delta_1st_compute #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int NUM_CEP     = 13,
    parameter int NUM_FRAMES  = 49,
    parameter int SCALE       = 6554,
    parameter int SCALE_SHIFT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);

    localparam int NW = DATA_WIDTH + 3;
    localparam int PW = NW + 33;

    localparam logic [ADDR_WIDTH-1:0] ZERO_A = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] TWO_A  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] LAST_T = ADDR_WIDTH'(NUM_FRAMES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(NUM_CEP - 1);
    localparam logic [ADDR_WIDTH-1:0] CEP_A  = ADDR_WIDTH'(NUM_CEP);
    localparam logic [ADDR_WIDTH:0]   LAST_E = {1'b0, LAST_T};
    localparam logic [ADDR_WIDTH:0]   ONE_E  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   TWO_E  = (ADDR_WIDTH + 1)'(2);

    localparam logic [31:0]          SCALE_U = 32'(SCALE);
    localparam logic signed [PW-1:0] SCALE_P = {{(NW + 1){1'b0}}, SCALE_U};
    localparam logic signed [PW-1:0] MAX_P   = {{(PW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_P   = {{(PW - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] MAX_D = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] MIN_D = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_RD_M2 = 4'd1,
        S_RD_M1 = 4'd2,
        S_RD_P1 = 4'd3,
        S_RD_P2 = 4'd4,
        S_WAIT  = 4'd5,
        S_CALC  = 4'd6,
        S_MUL   = 4'd7,
        S_WRITE = 4'd8,
        S_NEXT  = 4'd9,
        S_DONE  = 4'd10
    } state_t;

    state_t state_r, state_s;

    logic [ADDR_WIDTH-1:0]        t_r, k_r;
    logic signed [DATA_WIDTH-1:0] m2_r, m1_r, p1_r, p2_r;
    logic signed [NW-1:0]         num_r;
    logic signed [DATA_WIDTH-1:0] result_r;

    logic [ADDR_WIDTH:0]          t_ext_s, up1_s, up2_s;
    logic [ADDR_WIDTH-1:0]        fm2_s, fm1_s, fp1_s, fp2_s, rd_frame_s;
    logic                         last_coef_s;
    logic signed [NW-1:0]         num_s;
    logic signed [PW-1:0]         num_p_s, prod_s, shifted_s;
    logic signed [DATA_WIDTH-1:0] sat_s;

    function automatic logic signed [NW-1:0] sext(input logic signed [DATA_WIDTH-1:0] v);
        return {{3{v[DATA_WIDTH-1]}}, v};
    endfunction

    assign last_coef_s = (t_r == LAST_T) && (k_r == LAST_K);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; every read/compute step is a single cycle
    always_comb begin
        state_s = S_IDLE;
        case (state_r)
            S_IDLE:  begin
                if (start) begin
                    state_s = S_RD_M2;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RD_M2: state_s = S_RD_M1;
            S_RD_M1: state_s = S_RD_P1;
            S_RD_P1: state_s = S_RD_P2;
            S_RD_P2: state_s = S_WAIT;
            S_WAIT:  state_s = S_CALC;
            S_CALC:  state_s = S_MUL;
            S_MUL:   state_s = S_WRITE;
            S_WRITE: state_s = S_NEXT;
            S_NEXT:  begin
                if (last_coef_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_RD_M2;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Clamped neighbour frames; one extra bit keeps t+2 from wrapping
    always_comb begin
        t_ext_s = {1'b0, t_r};
        up1_s   = t_ext_s + ONE_E;
        up2_s   = t_ext_s + TWO_E;
        if (t_r >= TWO_A) begin
            fm2_s = t_r - TWO_A;
        end else begin
            fm2_s = ZERO_A;
        end
        if (t_r >= ONE_A) begin
            fm1_s = t_r - ONE_A;
        end else begin
            fm1_s = ZERO_A;
        end
        if (up1_s > LAST_E) begin
            fp1_s = LAST_T;
        end else begin
            fp1_s = up1_s[ADDR_WIDTH-1:0];
        end
        if (up2_s > LAST_E) begin
            fp2_s = LAST_T;
        end else begin
            fp2_s = up2_s[ADDR_WIDTH-1:0];
        end
    end

    // Numerator, scaled product and saturation to the output range
    always_comb begin
        num_s     = (sext(p1_r) - sext(m1_r)) + ((sext(p2_r) - sext(m2_r)) <<< 1);
        num_p_s   = {{33{num_r[NW-1]}}, num_r};
        prod_s    = num_p_s * SCALE_P;
        shifted_s = prod_s >>> SCALE_SHIFT;
        if (shifted_s > MAX_P) begin
            sat_s = MAX_D;
        end else if (shifted_s < MIN_P) begin
            sat_s = MIN_D;
        end else begin
            sat_s = shifted_s[DATA_WIDTH-1:0];
        end
    end

    // Indices, operand capture (data lands one cycle after its read) and result pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_r      <= ZERO_A;
            k_r      <= ZERO_A;
            m2_r     <= {DATA_WIDTH{1'b0}};
            m1_r     <= {DATA_WIDTH{1'b0}};
            p1_r     <= {DATA_WIDTH{1'b0}};
            p2_r     <= {DATA_WIDTH{1'b0}};
            num_r    <= {NW{1'b0}};
            result_r <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        t_r <= ZERO_A;
                        k_r <= ZERO_A;
                    end
                end
                S_RD_M1: m2_r  <= rd_data;
                S_RD_P1: m1_r  <= rd_data;
                S_RD_P2: p1_r  <= rd_data;
                S_WAIT:  p2_r  <= rd_data;
                S_CALC:  num_r <= num_s;
                S_MUL:   result_r <= sat_s;
                S_NEXT: begin
                    if (!last_coef_s) begin
                        if (k_r == LAST_K) begin
                            k_r <= ZERO_A;
                            t_r <= t_r + ONE_A;
                        end else begin
                            k_r <= k_r + ONE_A;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read frame selected by the issuing state
    always_comb begin
        case (state_r)
            S_RD_M2: rd_frame_s = fm2_s;
            S_RD_M1: rd_frame_s = fm1_s;
            S_RD_P1: rd_frame_s = fp1_s;
            S_RD_P2: rd_frame_s = fp2_s;
            default: rd_frame_s = ZERO_A;
        endcase
    end

    // Strobes and addresses decoded from state; addresses are zero while idle
    always_comb begin
        busy    = (state_r != S_IDLE);
        done    = (state_r == S_DONE);
        rd_en   = (state_r == S_RD_M2) || (state_r == S_RD_M1) ||
                  (state_r == S_RD_P1) || (state_r == S_RD_P2);
        wr_en   = (state_r == S_WRITE);
        wr_data = result_r;
        if (rd_en) begin
            rd_addr = rd_frame_s * CEP_A + k_r;
        end else begin
            rd_addr = ZERO_A;
        end
        if (wr_en) begin
            wr_addr = t_r * CEP_A + k_r;
        end else begin
            wr_addr = ZERO_A;
        end
    end

endmodule

// File: tb/tb_delta_1st_compute.sv
// Bench for delta_1st_compute: default build, a 16-bit saturating build and a single-frame build,
// each checked against a plain-arithmetic model of the regression delta.
module tb_delta_1st_compute;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default instance
    logic        start = 1'b0, busy, done, rd_en, wr_en;
    logic [9:0]  rd_addr, wr_addr;
    logic [31:0] rd_data = 32'd0, wr_data;
    // saturation instance
    logic        s_start = 1'b0, s_busy, s_done, s_rd_en, s_wr_en;
    logic [9:0]  s_rd_addr, s_wr_addr;
    logic [15:0] s_rd_data = 16'd0, s_wr_data;
    // single-frame instance
    logic        o_start = 1'b0, o_busy, o_done, o_rd_en, o_wr_en;
    logic [9:0]  o_rd_addr, o_wr_addr;
    logic [31:0] o_rd_data = 32'd0, o_wr_data;

    delta_1st_compute dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

    delta_1st_compute #(.DATA_WIDTH(16), .NUM_CEP(2), .NUM_FRAMES(4), .SCALE(65536), .SCALE_SHIFT(0)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
        .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data));

    delta_1st_compute #(.NUM_CEP(4), .NUM_FRAMES(1)) dut_o (
        .clk(clk), .rst(rst), .start(o_start), .busy(o_busy), .done(o_done),
        .rd_en(o_rd_en), .rd_addr(o_rd_addr), .rd_data(o_rd_data),
        .wr_en(o_wr_en), .wr_addr(o_wr_addr), .wr_data(o_wr_data));

    logic signed [31:0] mem_m [0:636];
    logic signed [15:0] mem_s [0:7];
    logic signed [31:0] mem_o [0:3];
    logic signed [31:0] wmem_m [0:636];
    logic signed [15:0] wmem_s [0:7];
    logic signed [31:0] wmem_o [0:3];
    int wr_commit_m = 0, wr_commit_s = 0, wr_commit_o = 0;

    int     exp_ra_m[$];
    int     exp_wa_m[$], exp_wa_s[$], exp_wa_o[$];
    longint exp_wd_m[$], exp_wd_s[$], exp_wd_o[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc_n = 0;
    int last_rd_cyc = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // delta from the regression formula with floor division and saturation
    function automatic longint model_delta(input longint cm2, input longint cm1, input longint cp1,
                                           input longint cp2, input longint scale, input int shift,
                                           input int dw);
        longint num, prod, dv, q, hi, lo;
        num  = (cp1 - cm1) + 2 * (cp2 - cm2);
        prod = num * scale;
        dv   = longint'(1) << shift;
        q    = prod / dv;
        if ((prod % dv) != 0 && prod < 0) q = q - 1;
        hi = (longint'(1) << (dw - 1)) - 1;
        lo = -(longint'(1) << (dw - 1));
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return q;
    endfunction

    function automatic longint get_c(input int which, input int t, input int k);
        case (which)
            0:       return longint'(mem_m[t * 13 + k]);
            1:       return longint'(mem_s[t * 2 + k]);
            default: return longint'(mem_o[k]);
        endcase
    endfunction

    task automatic build_exp(input int which);
        int nf, nc, fm2, fm1, fp1, fp2;
        longint d;
        nf = (which == 0) ? 49 : ((which == 1) ? 4 : 1);
        nc = (which == 0) ? 13 : ((which == 1) ? 2 : 4);
        if (which == 0) begin exp_ra_m.delete(); exp_wa_m.delete(); exp_wd_m.delete(); end
        if (which == 1) begin exp_wa_s.delete(); exp_wd_s.delete(); end
        if (which == 2) begin exp_wa_o.delete(); exp_wd_o.delete(); end
        for (int t = 0; t < nf; t++) begin
            fm2 = (t - 2 < 0) ? 0 : t - 2;
            fm1 = (t - 1 < 0) ? 0 : t - 1;
            fp1 = (t + 1 > nf - 1) ? nf - 1 : t + 1;
            fp2 = (t + 2 > nf - 1) ? nf - 1 : t + 2;
            for (int k = 0; k < nc; k++) begin
                if (which == 1)
                    d = model_delta(get_c(1, fm2, k), get_c(1, fm1, k), get_c(1, fp1, k), get_c(1, fp2, k), 65536, 0, 16);
                else
                    d = model_delta(get_c(which, fm2, k), get_c(which, fm1, k), get_c(which, fp1, k), get_c(which, fp2, k), 6554, 16, 32);
                case (which)
                    0: begin
                        exp_ra_m.push_back(fm2 * nc + k); exp_ra_m.push_back(fm1 * nc + k);
                        exp_ra_m.push_back(fp1 * nc + k); exp_ra_m.push_back(fp2 * nc + k);
                        exp_wa_m.push_back(t * nc + k);   exp_wd_m.push_back(d);
                    end
                    1: begin exp_wa_s.push_back(t * nc + k); exp_wd_s.push_back(d); end
                    default: begin exp_wa_o.push_back(k); exp_wd_o.push_back(d); end
                endcase
            end
        end
    endtask

    task automatic fill_main(input int mode);
        for (int t = 0; t < 49; t++)
            for (int k = 0; k < 13; k++) begin
                case (mode)
                    0:       mem_m[t * 13 + k] = 32'(10 * t);
                    1:       mem_m[t * 13 + k] = 32'(-10 * t);
                    default: mem_m[t * 13 + k] = 32'((((t * 37 + k * 11) % 101) - 50) * 1000003);
                endcase
                wmem_m[t * 13 + k] = 32'h7ead_beef;
            end
        wr_commit_m = 0;
    endtask

    // synchronous cepstrum RAMs and delta-1 write capture
    always @(posedge clk) begin
        if (rd_en)   rd_data   <= mem_m[rd_addr];
        if (s_rd_en) s_rd_data <= mem_s[s_rd_addr];
        if (o_rd_en) o_rd_data <= mem_o[o_rd_addr];
    end

    initial forever begin
        @(posedge clk);
        if (wr_en)   begin wmem_m[wr_addr] = wr_data;     wr_commit_m++; end
        if (s_wr_en) begin wmem_s[s_wr_addr] = s_wr_data; wr_commit_s++; end
        if (o_wr_en) begin wmem_o[o_wr_addr] = o_wr_data; wr_commit_o++; end
    end

    // compare process: every read and write against the model's ordered streams
    initial forever begin
        @(negedge clk);
        cyc_n++;
        if (!rst) begin
            if (rd_en) begin
                chk("rd_expected", longint'(exp_ra_m.size() > 0), 1);
                if (exp_ra_m.size() > 0) chk("rd_addr", rd_addr, exp_ra_m.pop_front());
                last_rd_cyc = cyc_n;
            end else begin
                chk("rd_addr_idle", rd_addr, 0);
            end
            if (wr_en) begin
                chk("wr_expected", longint'(exp_wa_m.size() > 0), 1);
                if (exp_wa_m.size() > 0) begin
                    chk("wr_addr", wr_addr, exp_wa_m.pop_front());
                    chk("wr_data", longint'($signed(wr_data)), exp_wd_m.pop_front());
                end
                chk("rd_to_wr_latency", cyc_n - last_rd_cyc, 4);
            end else begin
                chk("wr_addr_idle", wr_addr, 0);
            end
            if (s_wr_en) begin
                chk("s_wr_expected", longint'(exp_wa_s.size() > 0), 1);
                if (exp_wa_s.size() > 0) begin
                    chk("s_wr_addr", s_wr_addr, exp_wa_s.pop_front());
                    chk("s_wr_data", longint'($signed(s_wr_data)), exp_wd_s.pop_front());
                end
            end
            if (o_wr_en) begin
                chk("o_wr_expected", longint'(exp_wa_o.size() > 0), 1);
                if (exp_wa_o.size() > 0) begin
                    chk("o_wr_addr", o_wr_addr, exp_wa_o.pop_front());
                    chk("o_wr_data", longint'($signed(o_wr_data)), exp_wd_o.pop_front());
                end
            end
        end
    end

    task automatic run_main(input int mode, input bit spur, input bit start_at_done);
        int cyc;
        bit seen;
        fill_main(mode);
        build_exp(0);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 6000) begin
            @(posedge clk); cyc++; #1;
            start = (spur && cyc == 1000);
            if (cyc == 500) chk("busy_mid_run", busy, 1);
            if (done) seen = 1'b1;
        end
        chk("done_seen", seen, 1);
        chk("done_cycle", cyc, 5733);
        chk("busy_at_done", busy, 1);
        start = start_at_done;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        repeat (3) @(posedge clk);
        #1 chk("idle_after_run", {busy, rd_en}, 0);
        chk("write_count", wr_commit_m, 637);
        chk("writes_left", exp_wa_m.size(), 0);
        chk("reads_left", exp_ra_m.size(), 0);
    endtask

    task automatic run_small(input int which, input int exp_cyc, input int exp_wr);
        int cyc;
        bit seen;
        build_exp(which);
        @(negedge clk);
        if (which == 1) s_start = 1'b1; else o_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0; o_start = 1'b0;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 300) begin
            @(posedge clk); cyc++; #1;
            if ((which == 1) ? s_done : o_done) seen = 1'b1;
        end
        chk("small_done_seen", seen, 1);
        chk("small_done_cycle", cyc, exp_cyc);
        chk("small_write_count", (which == 1) ? wr_commit_s : wr_commit_o, exp_wr);
        chk("small_writes_left", (which == 1) ? exp_wa_s.size() : exp_wa_o.size(), 0);
    endtask

    initial begin
        int found;
        for (int t = 0; t < 4; t++) begin
            mem_s[t * 2]     = 16'(10000 * t);
            mem_s[t * 2 + 1] = 16'(-10000 * t);
        end
        for (int k = 0; k < 4; k++) mem_o[k] = 32'(1234 * (k + 1) + 77);

        // model pinned to hand-computed values
        chk("model_ramp_interior", model_delta(0, 10, 30, 40, 6554, 16, 32), 10);
        chk("model_ramp_edge", model_delta(0, 0, 10, 20, 6554, 16, 32), 5);
        chk("model_neg_floor", model_delta(0, -10, -30, -40, 6554, 16, 32), -11);
        chk("model_sat_pos", model_delta(0, 10000, 30000, 40000, 65536, 0, 16), 32767);
        chk("model_sat_neg", model_delta(0, -10000, -30000, -40000, 65536, 0, 16), -32768);

        repeat (3) @(posedge clk);
        #1 chk("outputs_in_reset", {busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data}, 0);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("idle_outputs", {busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data}, 0);
        end

        run_main(0, 1'b0, 1'b0);
        chk("ramp_frame0", wmem_m[0], 5);
        chk("ramp_frame1", wmem_m[13], 8);
        chk("ramp_interior", wmem_m[20 * 13 + 4], 10);
        chk("ramp_frame48", wmem_m[48 * 13 + 12], 5);

        run_main(1, 1'b1, 1'b1);
        chk("negramp_interior", wmem_m[10 * 13 + 7], -11);
        chk("negramp_frame0", wmem_m[0], -6);

        // reset during WRITE of frame 3, k=0
        fill_main(2);
        build_exp(0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            @(negedge clk);
            if (wr_en && wr_addr == 10'd39) found = 1;
        end
        chk("reached_frame3_write", found, 1);
        #1 rst = 1'b1;
        #1 chk("outputs_on_reset", {busy, done, rd_en, wr_en, rd_addr, wr_addr}, 0);
        @(posedge clk);
        #1 chk("no_write_under_reset", wr_commit_m, 39);
        chk("sentinel_kept", wmem_m[39], 32'sh7ead_beef);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);

        run_main(2, 1'b1, 1'b0);

        run_small(1, 72, 8);
        chk("sat_pos", wmem_s[2], 32767);
        chk("sat_neg", wmem_s[3], -32768);
        run_small(2, 36, 4);
        for (int k = 0; k < 4; k++) chk("single_frame_zero", wmem_o[k], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
